// File: rtl/acc_fwd_streamer_if.sv
// acc_fwd_streamer_if
//   Bundles the two streaming links of the accelerator forwarding transmitter:
//   the data-memory read port and the fwd_data/fwd_valid element stream.
//   Optional macro ACC_FWD_IDX_EN adds the per-element (row, col) index lines.
//
//   Signals (directions as seen from the streamer, modport master):
//     mem_req_o    out  read request valid
//     mem_addr_o   out  read byte address
//     mem_gnt_i    in   request accepted this cycle
//     mem_rvalid_i in   in-order read response valid
//     mem_rdata_i  in   read response data
//     fwd_valid_o  out  fwd_data_o holds a valid element
//     fwd_data_o   out  forwarded element
//     fwd_ready_i  in   consumer accepts the element this cycle
//     fwd_row_o    out  row index of the head element   (ACC_FWD_IDX_EN only)
//     fwd_col_o    out  column index of the head element (ACC_FWD_IDX_EN only)
//   modport slave is the mirror image (memory model + consumer side).
interface acc_fwd_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
`ifdef ACC_FWD_IDX_EN
  , parameter int DIM_W = 16
`endif
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              fwd_valid_o;
  logic [DATA_W-1:0] fwd_data_o;
  logic              fwd_ready_i;
`ifdef ACC_FWD_IDX_EN
  logic [DIM_W-1:0]  fwd_row_o;
  logic [DIM_W-1:0]  fwd_col_o;
`endif

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output fwd_valid_o, fwd_data_o,
    input  fwd_ready_i
`ifdef ACC_FWD_IDX_EN
    , output fwd_row_o, fwd_col_o
`endif
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  fwd_valid_o, fwd_data_o,
    output fwd_ready_i
`ifdef ACC_FWD_IDX_EN
    , input fwd_row_o, fwd_col_o
`endif
  );
endinterface

// File: rtl/acc_fwd_streamer.sv
// acc_fwd_streamer
//   Transmitter side of the accelerator forwarding interface. Walks an MxN
//   row-major matrix band by band in the order the pivot controller consumes
//   it (pivot row of the band, then for every other row A[i,q] followed by the
//   band columns except q), reads each element from data memory and presents
//   it on a valid/ready stream through a credit-limited response FIFO.
//   Optional macro ACC_FWD_IDX_EN adds fwd_row_o/fwd_col_o on the interface.
//
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     start_i           one-cycle pulse in IDLE: latch config, begin streaming
//     base_addr_i       byte address of A[0,0] (4-byte elements)
//     m_i, n_i, w_i     rows, columns, band width
//     p_i, q_i          pivot row / pivot column
//     busy_o            high from accepted start until the stream is drained
//     done_o            one-cycle pulse once the last element is consumed
//     bus               acc_fwd_streamer_if.master (memory port + fwd stream)
module acc_fwd_streamer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  input  logic [DIM_W-1:0]   m_i,
  input  logic [DIM_W-1:0]   n_i,
  input  logic [DIM_W-1:0]   w_i,
  input  logic [DIM_W-1:0]   p_i,
  input  logic [DIM_W-1:0]   q_i,
  output logic               busy_o,
  output logic               done_o,
  acc_fwd_streamer_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = DIM_W + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ROW_P, ROW_IQ, ROW_IJ, DRAIN} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  m_q, n_q, w_q, p_q, q_q;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, band_q, band_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, inflight_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [IDX_W-1:0]  band_lim, band_end, first_row, next_row, first_ij, next_ij;
  logic [IDX_W-1:0]  row_sel, col_sel;
  logic [CNT_W:0]    credit_used;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_req, fire, push, pop, fwd_valid;

  // Walk helpers: band_end is the exclusive last column of the current band;
  // row and column steps skip p and q respectively.
  always_comb begin
    band_lim  = band_q + w_q;
    band_end  = (band_lim < n_q) ? band_lim : n_q;
    first_row = (p_q == '0) ? IDX_W'(1) : '0;
    next_row  = (i_q + IDX_W'(1) == p_q) ? i_q + IDX_W'(2) : i_q + IDX_W'(1);
    first_ij  = (band_q == q_q) ? band_q + IDX_W'(1) : band_q;
    next_ij   = (j_q + IDX_W'(1) == q_q) ? j_q + IDX_W'(2) : j_q + IDX_W'(1);
  end

  always_comb begin
    row_sel = i_q;
    col_sel = j_q;
    if (state_q == ROW_P)  row_sel = p_q;
    if (state_q == ROW_IQ) col_sel = q_q;
  end

  // Credit covers both buffered and outstanding reads, so every response has
  // a free FIFO slot. The sum only shrinks while a request waits for grant,
  // which keeps mem_req_o and the address stable until accepted.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign mem_req     = (state_q == ROW_P || state_q == ROW_IQ || state_q == ROW_IJ) &&
                       (credit_used < CREDIT_MAX);
  assign fire        = mem_req && bus.mem_gnt_i;
  assign req_addr    = base_q + ((ADDR_W'(row_sel) * ADDR_W'(n_q) + ADDR_W'(col_sel)) << 2);
  assign push        = bus.mem_rvalid_i;
  assign fwd_valid   = (count_q != '0);
  assign pop         = fwd_valid && bus.fwd_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    band_d  = band_q;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          i_d     = '0;
          j_d     = '0;
          band_d  = '0;
          state_d = (m_i == '0 || n_i == '0 || w_i == '0) ? DRAIN : ROW_P;
        end
      end
      ROW_P: begin
        if (fire) begin
          if (j_q + IDX_W'(1) < band_end) j_d = j_q + IDX_W'(1);
          else if (first_row < m_q) begin
            i_d     = first_row;
            state_d = ROW_IQ;
          end else if (band_lim < n_q) begin
            band_d  = band_lim;
            j_d     = band_lim;
          end else state_d = DRAIN;
        end
      end
      ROW_IQ: begin
        if (fire) begin
          if (first_ij < band_end) begin
            j_d     = first_ij;
            state_d = ROW_IJ;
          end else if (next_row < m_q) begin
            i_d     = next_row;
          end else if (band_lim < n_q) begin
            band_d  = band_lim;
            j_d     = band_lim;
            state_d = ROW_P;
          end else state_d = DRAIN;
        end
      end
      ROW_IJ: begin
        if (fire) begin
          if (next_ij < band_end) j_d = next_ij;
          else if (next_row < m_q) begin
            i_d     = next_row;
            state_d = ROW_IQ;
          end else if (band_lim < n_q) begin
            band_d  = band_lim;
            j_d     = band_lim;
            state_d = ROW_P;
          end else state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0 && inflight_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0;
      m_q    <= '0;
      n_q    <= '0;
      w_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      band_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      band_q <= band_d;
      if (state_q == IDLE && start_i) begin
        base_q <= base_addr_i;
        m_q    <= IDX_W'(m_i);
        n_q    <= IDX_W'(n_i);
        w_q    <= IDX_W'(w_i);
        p_q    <= IDX_W'(p_i);
        q_q    <= IDX_W'(q_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      unique case ({fire, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mem_rdata_i;
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_req ? req_addr : '0;
  assign bus.fwd_valid_o = fwd_valid;
  assign bus.fwd_data_o  = fwd_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy_o          = (state_q != IDLE);

`ifdef ACC_FWD_IDX_EN
  // Indices enter at grant time and leave on the forward pop. Entries live
  // from grant to pop, so the credit limit also bounds this queue, and its
  // read side advances in lockstep with the data FIFO (shared read pointer).
  logic [DIM_W-1:0] idx_row_mem [FIFO_DEPTH];
  logic [DIM_W-1:0] idx_col_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] idx_wr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     idx_wr_q <= '0;
    else if (fire) idx_wr_q <= idx_wr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (fire) begin
      idx_row_mem[idx_wr_q] <= row_sel[DIM_W-1:0];
      idx_col_mem[idx_wr_q] <= col_sel[DIM_W-1:0];
    end
  end

  assign bus.fwd_row_o = fwd_valid ? idx_row_mem[rd_ptr_q] : '0;
  assign bus.fwd_col_o = fwd_valid ? idx_col_mem[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_acc_fwd_streamer.sv
`timescale 1ns/1ps
module tb_acc_fwd_streamer;
  localparam int DATA_W = 32, ADDR_W = 32, DIM_W = 16, FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [DIM_W-1:0]  m = '0, n = '0, w = '0, p = '0, q = '0;
  logic              busy, done;

  acc_fwd_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  acc_fwd_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
    .m_i(m), .n_i(n), .w_i(w), .p_i(p), .q_i(q),
    .busy_o(busy), .done_o(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, n_grants = 0, done_cnt = 0;
  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit start_pend = 1'b0;
  logic [31:0] resp_q[$];
  int          due_q[$];
  logic [31:0] got_q[$];
  logic [31:0] addr_log[$];
  int          exp_i[$], exp_j[$];
`ifdef ACC_FWD_IDX_EN
  logic [DIM_W-1:0] got_row[$], got_col[$];
`endif

  // Memory contents: an odd-multiplier hash of the byte address (bijective).
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] exp_addr(input int i, input int j);
    return base + 32'((i * int'(n) + j) << 2);
  endfunction

  function automatic logic [31:0] exp_data(input int k);
    return mem_val(exp_addr(exp_i[k], exp_j[k]));
  endfunction

  // Reference order, straight from the band/row rules.
  task automatic build_model();
    int mi, ni, wi, pi, qi, hi;
    exp_i.delete(); exp_j.delete();
    mi = int'(m); ni = int'(n); wi = int'(w); pi = int'(p); qi = int'(q);
    if (mi == 0 || ni == 0 || wi == 0) return;
    for (int lo = 0; lo < ni; lo += wi) begin
      hi = (lo + wi < ni) ? lo + wi : ni;
      for (int j = lo; j < hi; j++) begin exp_i.push_back(pi); exp_j.push_back(j); end
      for (int i = 0; i < mi; i++) begin
        if (i == pi) continue;
        exp_i.push_back(i); exp_j.push_back(qi);
        for (int j = lo; j < hi; j++)
          if (j != qi) begin exp_i.push_back(i); exp_j.push_back(j); end
      end
    end
  endtask

  // One clock of the memory model and consumer: sample DUT outputs at the
  // falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    logic g, r;
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = resp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    g = bus.mem_req_o && ($urandom_range(99) < gnt_pct);
    if (g) begin
      addr_log.push_back(bus.mem_addr_o);
      resp_q.push_back(mem_val(bus.mem_addr_o));
      due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      n_grants++;
    end
    bus.mem_gnt_i = g;
    r = ($urandom_range(99) < rdy_pct);
    bus.fwd_ready_i = r;
    if (bus.fwd_valid_o && r) begin
      got_q.push_back(bus.fwd_data_o);
`ifdef ACC_FWD_IDX_EN
      got_row.push_back(bus.fwd_row_o);
      got_col.push_back(bus.fwd_col_o);
`endif
    end
    start = start_pend;
    start_pend = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] b, input int mv, input int nv, input int wv,
                           input int pv, input int qv);
    base = b; m = DIM_W'(mv); n = DIM_W'(nv); w = DIM_W'(wv); p = DIM_W'(pv); q = DIM_W'(qv);
    got_q.delete(); addr_log.delete();
`ifdef ACC_FWD_IDX_EN
    got_row.delete(); got_col.delete();
`endif
    n_grants = 0; done_cnt = 0;
    build_model();
    start_pend = 1'b1;
    tick();
  endtask

  task automatic run_to_done(input string name, input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin tick(); c++; end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout done_seen=0 required=1 after %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.fwd_ready_i = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr_o); end
    checks++; if (bus.fwd_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.fwd_valid_o); end
    checks++; if (bus.fwd_data_o !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", bus.fwd_data_o); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int ti[14] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 1, 2, 2, 2};
    int tj[14] = '{0, 1, 1, 0, 1, 0, 2, 3, 1, 2, 3, 1, 2, 3};
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    start_run(32'h1000, 3, 4, 2, 0, 1);
    run_to_done("basic", 200);
    checks++;
    if (got_q.size() != 14) begin failures++; $display("FAIL basic_count got=%0d exp=14", got_q.size()); end
    for (int k = 0; k < 14 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== mem_val(exp_addr(ti[k], tj[k]))) begin
        failures++; $display("FAIL basic_elem[%0d] got=%h exp=%h (A%0d%0d)", k, got_q[k], mem_val(exp_addr(ti[k], tj[k])), ti[k], tj[k]);
      end
    end
    checks++;
    if (addr_log.size() < 14 || addr_log[0] !== 32'h1000 || addr_log[13] !== 32'h102C) begin
      failures++; $display("FAIL basic_addr grants=%0d first=%h last=%h exp first=00001000 last=0000102c",
                           addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 32'h0, addr_log.size() > 13 ? addr_log[13] : 32'h0);
    end
    repeat (3) tick();
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
    start_run(32'h1000, 3, 4, 2, 0, 1);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.fwd_valid_o) begin
        checks++;
        if (bus.fwd_data_o !== exp_data(0)) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, bus.fwd_data_o, exp_data(0));
        end
      end
    end
    checks++; if (n_grants != FIFO_DEPTH) begin failures++; $display("FAIL bp_grants got=%0d exp=%0d", n_grants, FIFO_DEPTH); end
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%b exp=0", bus.mem_req_o); end
    checks++; if (bus.fwd_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.fwd_valid_o); end
    rdy_pct = 100;
    run_to_done("bp", 300);
    checks++;
    if (got_q.size() != exp_i.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_i.size()); end
    for (int k = 0; k < exp_i.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_data(k)) begin failures++; $display("FAIL bp_elem[%0d] got=%h exp=%h", k, got_q[k], exp_data(k)); end
    end
  endtask

  task automatic test_partial_band();
    int sz;
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 2;
    start_run(32'h0000_2000, 2, 5, 2, 1, 4);
    run_to_done("partial", 300);
    sz = got_q.size();
    checks++;
    if (sz != exp_i.size()) begin failures++; $display("FAIL partial_count got=%0d exp=%0d", sz, exp_i.size()); end
    for (int k = 0; k < exp_i.size() && k < sz; k++) begin
      checks++;
      if (got_q[k] !== exp_data(k)) begin failures++; $display("FAIL partial_elem[%0d] got=%h exp=%h", k, got_q[k], exp_data(k)); end
    end
    checks++;
    if (sz < 2 || got_q[sz-2] !== mem_val(exp_addr(1, 4)) || got_q[sz-1] !== mem_val(exp_addr(0, 4))) begin
      failures++; $display("FAIL partial_last_band size=%0d exp tail A14=%h A04=%h", sz, mem_val(exp_addr(1, 4)), mem_val(exp_addr(0, 4)));
    end
  endtask

  task automatic test_zero_dims();
    int cfg[3][3] = '{'{0, 4, 2}, '{3, 0, 2}, '{3, 4, 0}};
    for (int t = 0; t < 3; t++) begin
      start_run(32'h3000, cfg[t][0], cfg[t][1], cfg[t][2], 0, 0);
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero%0d_done_c1 got=%b exp=1", t, done); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero%0d_busy_c1 got=%b exp=1", t, busy); end
      checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL zero%0d_req got=%b exp=0", t, bus.mem_req_o); end
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL zero%0d_c2 busy=%b done=%b exp 0 0", t, busy, done); end
      checks++; if (n_grants != 0) begin failures++; $display("FAIL zero%0d_grants got=%0d exp=0", t, n_grants); end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    gnt_pct = 100; rdy_pct = 50; lat_min = 1; lat_max = 3;
    start_run(32'h1000, 3, 4, 2, 0, 1);
    while (n_grants < 5 && c < 200) begin tick(); c++; end
    checks++; if (n_grants < 5) begin failures++; $display("FAIL rmid_grants got=%0d exp=5", n_grants); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_ctrl busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== '0) begin failures++; $display("FAIL rmid_mem req=%b addr=%h exp 0 0", bus.mem_req_o, bus.mem_addr_o); end
    checks++; if (bus.fwd_valid_o !== 1'b0 || bus.fwd_data_o !== '0) begin failures++; $display("FAIL rmid_fwd valid=%b data=%h exp 0 0", bus.fwd_valid_o, bus.fwd_data_o); end
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.fwd_ready_i = 0;
    resp_q.delete(); due_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_run(32'h0000_4000, 3, 4, 2, 2, 1);
    run_to_done("rmid", 400);
    checks++;
    if (addr_log.size() == 0 || addr_log[0] !== exp_addr(2, 0)) begin
      failures++; $display("FAIL rmid_first_addr got=%h exp=%h", addr_log.size() > 0 ? addr_log[0] : 32'h0, exp_addr(2, 0));
    end
    checks++;
    if (got_q.size() != exp_i.size()) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_i.size()); end
    for (int k = 0; k < exp_i.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_data(k)) begin failures++; $display("FAIL rmid_elem[%0d] got=%h exp=%h", k, got_q[k], exp_data(k)); end
    end
  endtask

  task automatic test_random();
    int mv, nv;
    for (int it = 0; it < 20; it++) begin
      mv = int'($urandom_range(5, 1));
      nv = int'($urandom_range(9, 1));
      gnt_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 30));
      lat_min = 1; lat_max = 6;
      start_run($urandom & 32'hFFFF_FFFC, mv, nv, int'($urandom_range(nv + 1, 1)),
                int'($urandom_range(mv)), int'($urandom_range(nv)));
      run_to_done("rand", 5000);
      checks++;
      if (got_q.size() != exp_i.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_q.size(), exp_i.size()); end
      for (int k = 0; k < exp_i.size() && k < got_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_data(k)) begin failures++; $display("FAIL rand%0d_elem[%0d] got=%h exp=%h", it, k, got_q[k], exp_data(k)); end
`ifdef ACC_FWD_IDX_EN
        checks++;
        if (got_row[k] !== DIM_W'(exp_i[k]) || got_col[k] !== DIM_W'(exp_j[k])) begin
          failures++; $display("FAIL rand%0d_idx[%0d] got=(%0d,%0d) exp=(%0d,%0d)", it, k, got_row[k], got_col[k], exp_i[k], exp_j[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_partial_band();
    test_zero_dims();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
